// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_if.sv
// Handshake bundle between the gate1 IJTAG TDR / functional path and the
// data mux select controller.
interface firebird7_in_gate1_tessent_data_mux_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             ijtag_req;
  logic             ijtag_err_clr;
  logic             func_busy;
  logic             ijtag_ack;
  logic             func_stall;
  logic             ijtag_select;
  logic             data_valid;
  logic             timeout_err;
  logic [CNT_W-1:0] switch_count;

  modport master (
    output ijtag_req, ijtag_err_clr, func_busy,
    input  ijtag_ack, func_stall, ijtag_select, data_valid, timeout_err, switch_count
  );

  modport slave (
    input  ijtag_req, ijtag_err_clr, func_busy,
    output ijtag_ack, func_stall, ijtag_select, data_valid, timeout_err, switch_count
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Sequences the gate1 IJTAG/functional data mux select: stall, drain, settle,
// grant, settle back. All outputs are flops loaded from the next-state decode.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DRAIN_TIMEOUT = 255,
  parameter int unsigned CNT_W         = 8
) (
  input logic ijtag_tck,
  input logic ijtag_reset,
  firebird7_in_gate1_tessent_data_mux_ctrl_if.slave bus
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DRN_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_FUNC       = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_SETTLE_IN  = 3'd2,
    ST_IJTAG      = 3'd3,
    ST_SETTLE_OUT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [DRN_W-1:0] drn_cnt_q, drn_cnt_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic             err_q, err_d, err_set;
  logic             sel_q, sel_d;
  logic             stall_q, stall_d;
  logic             ack_q, ack_d;
  logic             valid_q, valid_d;

  // State, counter and output registers
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q   <= ST_FUNC;
      set_cnt_q <= '0;
      drn_cnt_q <= '0;
      sw_cnt_q  <= '0;
      err_q     <= 1'b0;
      sel_q     <= 1'b0;
      stall_q   <= 1'b0;
      ack_q     <= 1'b0;
      valid_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      sw_cnt_q  <= sw_cnt_d;
      err_q     <= err_d;
      sel_q     <= sel_d;
      stall_q   <= stall_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state, counters, sticky error and switch count
  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    drn_cnt_d = drn_cnt_q;
    err_set   = 1'b0;
    unique case (state_q)
      ST_FUNC: begin
        if (bus.ijtag_req) begin
          state_d   = ST_DRAIN;
          drn_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (!bus.ijtag_req) begin
          state_d = ST_FUNC;
        end else if (!bus.func_busy) begin
          state_d   = ST_SETTLE_IN;
          set_cnt_d = '0;
        end else if (drn_cnt_q == DRN_W'(DRAIN_TIMEOUT - 1)) begin
          // Functional side never drained: force the switch and flag it
          state_d   = ST_SETTLE_IN;
          set_cnt_d = '0;
          err_set   = 1'b1;
        end else begin
          drn_cnt_d = drn_cnt_q + DRN_W'(1);
        end
      end
      ST_SETTLE_IN: begin
        if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) state_d = ST_IJTAG;
        else                                         set_cnt_d = set_cnt_q + SET_W'(1);
      end
      ST_IJTAG: begin
        if (!bus.ijtag_req) begin
          state_d   = ST_SETTLE_OUT;
          set_cnt_d = '0;
        end
      end
      ST_SETTLE_OUT: begin
        if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) state_d = ST_FUNC;
        else                                         set_cnt_d = set_cnt_q + SET_W'(1);
      end
      default: state_d = ST_FUNC;
    endcase

    sw_cnt_d = sw_cnt_q;
    if (state_q == ST_SETTLE_IN && state_d == ST_IJTAG && sw_cnt_q != CNT_MAX)
      sw_cnt_d = sw_cnt_q + CNT_W'(1);

    err_d = err_q;
    if (err_set)                err_d = 1'b1;
    else if (bus.ijtag_err_clr) err_d = 1'b0;
  end

  // Moore output decode of the upcoming state, loaded into the output flops
  always_comb begin
    sel_d   = 1'b0;
    stall_d = 1'b0;
    ack_d   = 1'b0;
    valid_d = 1'b1;
    unique case (state_d)
      ST_FUNC:       ;
      ST_DRAIN:      stall_d = 1'b1;
      ST_SETTLE_IN: begin
        sel_d   = 1'b1;
        stall_d = 1'b1;
        valid_d = 1'b0;
      end
      ST_IJTAG: begin
        sel_d   = 1'b1;
        stall_d = 1'b1;
        ack_d   = 1'b1;
      end
      ST_SETTLE_OUT: begin
        stall_d = 1'b1;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.ijtag_select = sel_q;
  assign bus.func_stall   = stall_q;
  assign bus.ijtag_ack    = ack_q;
  assign bus.data_valid   = valid_q;
  assign bus.timeout_err  = err_q;
  assign bus.switch_count = sw_cnt_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Directed bench for the gate1 data mux select controller.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  // {select, stall, ack, valid}
  localparam logic [3:0] S_FUNC = 4'b0001;
  localparam logic [3:0] S_DRN  = 4'b0101;
  localparam logic [3:0] S_SIN  = 4'b1100;
  localparam logic [3:0] S_IJ   = 4'b1111;
  localparam logic [3:0] S_SOUT = 4'b0100;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  firebird7_in_gate1_tessent_data_mux_ctrl_if #(.CNT_W(8)) bus ();

  firebird7_in_gate1_tessent_data_mux_ctrl #(
    .SETTLE_CYCLES(4), .DRAIN_TIMEOUT(255), .CNT_W(8)
  ) dut (
    .ijtag_tck  (clk),
    .ijtag_reset(rst),
    .bus        (bus)
  );

  function automatic logic [3:0] obs();
    return {bus.ijtag_select, bus.func_stall, bus.ijtag_ack, bus.data_valid};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [3:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (obs() === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    vectors++;
    if (obs() !== S_FUNC) begin
      miscompares++; $display("FAIL reset_outs: got %b want %b", obs(), S_FUNC);
    end
    vectors++;
    if (bus.timeout_err !== 1'b0 || bus.switch_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_err_cnt: got %b/%0d want 0/0", bus.timeout_err, bus.switch_count);
    end
  endtask

  task automatic test_grant_idle();
    bus.ijtag_req = 1'b1; bus.func_busy = 1'b0;
    step(1);
    vectors++;
    if (obs() !== S_DRN) begin
      miscompares++; $display("FAIL idle_drain: got %b want %b", obs(), S_DRN);
    end
    for (int i = 0; i < 4; i++) begin
      step(1);
      vectors++;
      if (obs() !== S_SIN) begin
        miscompares++; $display("FAIL idle_settle_in%0d: got %b want %b", i, obs(), S_SIN);
      end
    end
    step(1);
    exp_cnt++;
    vectors++;
    if (obs() !== S_IJ || bus.switch_count !== 8'(exp_cnt)) begin
      miscompares++;
      $display("FAIL idle_grant: got %b cnt %0d want %b cnt %0d", obs(), bus.switch_count, S_IJ, exp_cnt);
    end
    bus.ijtag_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      vectors++;
      if (obs() !== S_SOUT) begin
        miscompares++; $display("FAIL idle_settle_out%0d: got %b want %b", i, obs(), S_SOUT);
      end
    end
    step(1);
    vectors++;
    if (obs() !== S_FUNC) begin
      miscompares++; $display("FAIL idle_back_func: got %b want %b", obs(), S_FUNC);
    end
  endtask

  task automatic test_drain_busy();
    int  drn;
    bit  ok;
    bus.ijtag_req = 1'b1; bus.func_busy = 1'b1;
    drn = 0;
    step(1);
    if (obs() === S_DRN) drn++;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (obs() === S_DRN) drn++;
    end
    bus.func_busy = 1'b0;
    step(1);
    vectors++;
    if (drn != 11 || obs() !== S_SIN) begin
      miscompares++;
      $display("FAIL busy_drain_len: got %0d cyc then %b want 11 cyc then %b", drn, obs(), S_SIN);
    end
    vectors++;
    if (bus.timeout_err !== 1'b0) begin
      miscompares++; $display("FAIL busy_no_err: got %b want 0", bus.timeout_err);
    end
    step(3);
    exp_cnt++;
    vectors++;
    if (obs() !== S_SIN) begin
      miscompares++; $display("FAIL busy_settle_end: got %b want %b", obs(), S_SIN);
    end
    step(1);
    vectors++;
    if (obs() !== S_IJ || bus.switch_count !== 8'(exp_cnt)) begin
      miscompares++;
      $display("FAIL busy_grant: got %b cnt %0d want %b cnt %0d", obs(), bus.switch_count, S_IJ, exp_cnt);
    end
    bus.ijtag_req = 1'b0;
    wait_state(S_FUNC, 10, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL busy_release: got %b want %b", obs(), S_FUNC);
    end
  endtask

  task automatic test_timeout();
    int drn;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      bus.ijtag_req = 1'b1; bus.func_busy = 1'b1;
      drn = 0;
      step(1);
      if (obs() === S_DRN) drn++;
      for (int i = 0; i < 254; i++) begin
        step(1);
        if (obs() === S_DRN) drn++;
      end
      vectors++;
      if (drn != 255 || bus.timeout_err !== 1'b0) begin
        miscompares++;
        $display("FAIL to%0d_drain_len: got %0d cyc err %b want 255 cyc err 0", pass, drn, bus.timeout_err);
      end
      // Second pass: clear pulse lands on the same edge as the timeout
      if (pass == 1) bus.ijtag_err_clr = 1'b1;
      step(1);
      bus.ijtag_err_clr = 1'b0;
      vectors++;
      if (obs() !== S_SIN || bus.timeout_err !== 1'b1) begin
        miscompares++;
        $display("FAIL to%0d_forced: got %b err %b want %b err 1", pass, obs(), bus.timeout_err, S_SIN);
      end
      bus.func_busy = 1'b0;
      if (pass == 0) begin
        bus.ijtag_err_clr = 1'b1;
        step(1);
        bus.ijtag_err_clr = 1'b0;
        vectors++;
        if (bus.timeout_err !== 1'b0) begin
          miscompares++; $display("FAIL to_err_clr: got %b want 0", bus.timeout_err);
        end
      end
      wait_state(S_IJ, 10, ok);
      exp_cnt++;
      vectors++;
      if (!ok || bus.switch_count !== 8'(exp_cnt)) begin
        miscompares++;
        $display("FAIL to%0d_grant: got %b cnt %0d want %b cnt %0d", pass, obs(), bus.switch_count, S_IJ, exp_cnt);
      end
      bus.ijtag_req = 1'b0;
      wait_state(S_FUNC, 10, ok);
    end
  endtask

  task automatic test_abort();
    bus.ijtag_req = 1'b1; bus.func_busy = 1'b1;
    step(4);
    vectors++;
    if (obs() !== S_DRN) begin
      miscompares++; $display("FAIL abort_in_drain: got %b want %b", obs(), S_DRN);
    end
    bus.ijtag_req = 1'b0;
    step(1);
    vectors++;
    if (obs() !== S_FUNC || bus.switch_count !== 8'(exp_cnt) || bus.timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_func: got %b cnt %0d err %b want %b cnt %0d err 1",
               obs(), bus.switch_count, bus.timeout_err, S_FUNC, exp_cnt);
    end
    bus.func_busy = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.ijtag_req = 1'b1;
    wait_state(S_IJ, 10, ok);
    exp_cnt++;
    bus.ijtag_req = 1'b0;
    step(3);
    vectors++;
    if (obs() !== S_SOUT) begin
      miscompares++; $display("FAIL b2b_settle_out: got %b want %b", obs(), S_SOUT);
    end
    bus.ijtag_req = 1'b1;
    step(2);
    vectors++;
    if (obs() !== S_FUNC) begin
      miscompares++; $display("FAIL b2b_func_min: got %b want %b", obs(), S_FUNC);
    end
    step(1);
    vectors++;
    if (obs() !== S_DRN) begin
      miscompares++; $display("FAIL b2b_redrain: got %b want %b", obs(), S_DRN);
    end
    wait_state(S_IJ, 10, ok);
    exp_cnt++;
    vectors++;
    if (!ok || bus.switch_count !== 8'(exp_cnt)) begin
      miscompares++;
      $display("FAIL b2b_regrant: got %b cnt %0d want %b cnt %0d", obs(), bus.switch_count, S_IJ, exp_cnt);
    end
    bus.ijtag_req = 1'b0;
    wait_state(S_FUNC, 10, ok);
  endtask

  task automatic test_saturation();
    bit ok1, ok2;
    int expect_sat;
    while (exp_cnt < 257) begin
      bus.ijtag_req = 1'b1;
      wait_state(S_IJ, 10, ok1);
      exp_cnt++;
      expect_sat = (exp_cnt > 255) ? 255 : exp_cnt;
      if (exp_cnt >= 254) begin
        vectors++;
        if (!ok1 || bus.switch_count !== 8'(expect_sat)) begin
          miscompares++;
          $display("FAIL sat_grant%0d: got cnt %0d want %0d", exp_cnt, bus.switch_count, expect_sat);
        end
      end
      bus.ijtag_req = 1'b0;
      wait_state(S_FUNC, 10, ok2);
      if (!ok1 || !ok2) begin
        vectors++; miscompares++;
        $display("FAIL sat_handshake%0d: got %b want grant/release", exp_cnt, obs());
        break;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.ijtag_req = 1'b1;
    wait_state(S_IJ, 10, ok);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    vectors++;
    if (obs() !== S_FUNC || bus.switch_count !== 8'd0 || bus.timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_ijtag: got %b cnt %0d err %b want %b cnt 0 err 0",
               obs(), bus.switch_count, bus.timeout_err, S_FUNC);
    end
    step(2);
    vectors++;
    if (obs() !== S_SIN) begin
      miscompares++; $display("FAIL rst_reach_sin: got %b want %b", obs(), S_SIN);
    end
    rst = 1'b1; bus.func_busy = 1'b1;
    step(1);
    rst = 1'b0;
    bus.ijtag_req = 1'b0; bus.func_busy = 1'b0;
    vectors++;
    if (obs() !== S_FUNC || bus.switch_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_in_settle: got %b cnt %0d want %b cnt 0", obs(), bus.switch_count, S_FUNC);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ijtag_req = 1'b0;
    bus.ijtag_err_clr = 1'b0;
    bus.func_busy = 1'b0;
    test_reset();
    test_grant_idle();
    test_drain_busy();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
